// File: rtl/iram_boot_ctrl_pkg.sv
// Shared definitions for the instruction-RAM boot controller.
// State encodings, word geometry and the default iram depth.
// Optional feature macro: IRAM_BOOT_CHECKSUM_EN (see iram_boot_ctrl.sv).
package iram_boot_ctrl_pkg;

    // 3-bit state encoding shared with the CPU-side definitions.
    typedef enum logic [2:0] {
        StHdr  = 3'd0,
        StData = 3'd1,
        StCsum = 3'd2,
        StRun  = 3'd3,
        StErr  = 3'd4
    } boot_state_e;

    localparam int unsigned BytesPerWord = 4;
    localparam int unsigned IramDepth    = 1024;

    // Byte address of word index idx relative to base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/iram_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// The first byte of each group lands in [7:0]; the fourth byte completes the word, which is
// presented with a 1-cycle word_valid in the following cycle.
// Not affected by IRAM_BOOT_CHECKSUM_EN.
module iram_byte_packer
    import iram_boot_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx_q;
    logic [23:0] low_q;
    logic [31:0] word_q;
    logic        word_valid_q;

    // Collect bytes; clear drops any partial word so a restarted load begins at byte 0.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            idx_q        <= '0;
            low_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (byte_en) begin
                unique case (idx_q)
                    2'd0: low_q[7:0]   <= byte_data;
                    2'd1: low_q[15:8]  <= byte_data;
                    2'd2: low_q[23:16] <= byte_data;
                    default: begin
                        word_q       <= {byte_data, low_q};
                        word_valid_q <= 1'b1;
                    end
                endcase
                // Wraps 3 -> 0 after the last byte of a word.
                idx_q <= (idx_q == 2'(BytesPerWord - 1)) ? 2'd0 : idx_q + 2'd1;
            end
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: rtl/iram_boot_ctrl.sv
// Instruction-RAM boot controller.
// Streams a program from a byte source (header word N, then N data words, little-endian),
// writes it into iram while holding the CPU in reset, then hands the iram port to the CPU.
// Optional feature macro: IRAM_BOOT_CHECKSUM_EN adds a 32-bit trailer word that must equal
// the mod-2^32 sum of the data words; a mismatch ends in the error state.
module iram_boot_ctrl
    import iram_boot_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH     = IramDepth,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boot_req,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        cpu_ena,
    input  logic [31:0] cpu_addr,
    output logic        mem_ena,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        boot_busy,
    output logic        boot_err
);

`ifdef IRAM_BOOT_CHECKSUM_EN
    localparam boot_state_e AfterData = StCsum;
`else
    localparam boot_state_e AfterData = StRun;
`endif

    boot_state_e state_q;
    logic [31:0] n_q;
    logic [31:0] k_q;
    logic [31:0] addr_q;
    logic        cpu_rst_n_q;
`ifdef IRAM_BOOT_CHECKSUM_EN
    logic [31:0] sum_q;
`endif

    logic        byte_en;
    logic        pk_clear;
    logic [31:0] word;
    logic        word_valid;
    logic        is_run;
    logic        last_word;

    assign is_run     = (state_q == StRun);
    assign boot_busy  = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
    assign boot_err   = (state_q == StErr);
    assign cpu_rst_n  = cpu_rst_n_q;
    // Held low while reset is asserted so no byte is consumed by a controller being reset.
    assign byte_ready = rst_n && boot_busy;
    assign byte_en    = byte_valid && byte_ready;
    // Packer idles cleared whenever the loader is shut out, so a restart begins on byte 0.
    assign pk_clear   = is_run || (state_q == StErr);
    assign mem_we     = (state_q == StData) && word_valid;
    assign last_word  = (k_q == n_q - 32'd1);

    iram_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .byte_en    (byte_en),
        .byte_data  (byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Output mux: CPU passthrough in RUN, otherwise the write port with the address held.
    always_comb begin
        mem_ena   = mem_we;
        mem_addr  = addr_q;
        mem_wdata = word;
        if (is_run) begin
            mem_ena  = cpu_ena;
            mem_addr = cpu_addr;
        end else if (mem_we) begin
            mem_addr = word_addr(BASE_ADDR, k_q);
        end
    end

    // Load sequencer: header decode, word counting, checksum and the registered CPU reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StHdr;
            n_q         <= '0;
            k_q         <= '0;
            addr_q      <= BASE_ADDR;
            cpu_rst_n_q <= 1'b0;
`ifdef IRAM_BOOT_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            addr_q      <= mem_addr;
            cpu_rst_n_q <= is_run;
            unique case (state_q)
                StHdr: begin
                    if (word_valid) begin
                        n_q <= word;
                        k_q <= '0;
                        // Oversized images are rejected before any write can leave iram.
                        if (word == 32'd0) begin
                            state_q <= AfterData;
                        end else if (word > 32'(DEPTH)) begin
                            state_q <= StErr;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (word_valid) begin
                        k_q <= k_q + 32'd1;
`ifdef IRAM_BOOT_CHECKSUM_EN
                        sum_q <= sum_q + word;
`endif
                        if (last_word) begin
                            state_q <= AfterData;
                        end
                    end
                end
`ifdef IRAM_BOOT_CHECKSUM_EN
                StCsum: begin
                    if (word_valid) begin
                        state_q <= (word == sum_q) ? StRun : StErr;
                    end
                end
`endif
                StRun, StErr: begin
                    if (boot_req) begin
                        state_q <= StHdr;
                        n_q     <= '0;
                        k_q     <= '0;
`ifdef IRAM_BOOT_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= StHdr;
                end
            endcase
        end
    end

endmodule
